// File: rtl/mc_ctrl_fsm.sv
// Multi-cycle MIPS control unit: per-instruction state sequencing, datapath
// select/enable decode, illegal-encoding trap and saturating perf counters.
module mc_ctrl_fsm #(
  parameter bit          MEM_HANDSHAKE = 1'b1,
  parameter int unsigned CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             mem_to_reg,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             ext_zero,
  output logic [3:0]       alu_ctrl,
  output logic [1:0]       pc_source,
  output logic [3:0]       state,
  output logic             halted,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    StFetch  = 4'd0,
    StDecode = 4'd1,
    StMemAdr = 4'd2,
    StMemRd  = 4'd3,
    StMemWb  = 4'd4,
    StMemWr  = 4'd5,
    StRExec  = 4'd6,
    StRWb    = 4'd7,
    StBranch = 4'd8,
    StJump   = 4'd9,
    StIExec  = 4'd10,
    StIWb    = 4'd11,
    StTrap   = 4'd12
  } state_e;

  localparam logic [5:0] OpRType = 6'h00;
  localparam logic [5:0] OpJ     = 6'h02;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpSlti  = 6'h0A;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam logic [3:0] AluAdd = 4'b0010;
  localparam logic [3:0] AluSub = 4'b0110;
  localparam logic [3:0] AluAnd = 4'b0000;
  localparam logic [3:0] AluOr  = 4'b0001;
  localparam logic [3:0] AluSlt = 4'b0111;

  state_e state_q, state_d;
  logic   mem_rdy;
  logic   retire;
  logic   funct_ok;
  logic [3:0] funct_alu;

  assign mem_rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign state   = state_q;
  // Leaving a non-FETCH state for FETCH is exactly an instruction retirement.
  assign retire  = (state_d == StFetch) && (state_q != StFetch);

  // R-type funct to ALU operation decode.
  always_comb begin
    funct_ok  = 1'b1;
    funct_alu = AluAdd;
    unique case (funct)
      6'h20:   funct_alu = AluAdd;
      6'h22:   funct_alu = AluSub;
      6'h24:   funct_alu = AluAnd;
      6'h25:   funct_alu = AluOr;
      6'h2A:   funct_alu = AluSlt;
      default: begin
        funct_ok  = 1'b0;
        funct_alu = AluAnd;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StFetch;
    else     state_q <= state_d;
  end

  // Saturating counters; both freeze in TRAP.
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (state_q != StTrap && cycle_count != {CNT_W{1'b1}}) cycle_count <= cycle_count + 1'b1;
      if (retire && instr_count != {CNT_W{1'b1}}) instr_count <= instr_count + 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StFetch:  if (mem_rdy) state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OpLw, OpSw:                     state_d = StMemAdr;
          OpRType:                        state_d = StRExec;
          OpBeq, OpBne:                   state_d = StBranch;
          OpJ:                            state_d = StJump;
          OpAddi, OpAndi, OpOri, OpSlti:  state_d = StIExec;
          default:                        state_d = StTrap;
        endcase
      end
      StMemAdr: state_d = (opcode == OpLw) ? StMemRd : (opcode == OpSw) ? StMemWr : StTrap;
      StMemRd:  if (mem_rdy) state_d = StMemWb;
      StMemWb:  state_d = StFetch;
      StMemWr:  if (mem_rdy) state_d = StFetch;
      StRExec:  state_d = funct_ok ? StRWb : StTrap;
      StRWb:    state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:   state_d = StFetch;
      StIExec:  state_d = StIWb;
      StIWb:    state_d = StFetch;
      StTrap:   state_d = StTrap;
      default:  state_d = StTrap;
    endcase
  end

  // Moore output decode, with reset overriding every strobe and enable.
  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    iord          = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    ext_zero      = 1'b0;
    alu_ctrl      = AluAnd;
    pc_source     = 2'b00;
    halted        = 1'b0;
    unique case (state_q)
      StFetch: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_ctrl  = AluAdd;
        ir_write  = mem_rdy;
        pc_write  = mem_rdy;
      end
      StDecode: begin
        alu_src_b = 2'b11;
        alu_ctrl  = AluAdd;
      end
      StMemAdr: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_ctrl  = AluAdd;
      end
      StMemRd: begin
        iord     = 1'b1;
        mem_read = 1'b1;
      end
      StMemWb: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      StRExec: begin
        alu_src_a = 1'b1;
        alu_ctrl  = funct_alu;
      end
      StRWb: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_ctrl      = AluSub;
        pc_source     = 2'b01;
        pc_write_cond = (opcode == OpBne) ? ~zero : zero;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      StIExec: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        ext_zero  = (opcode == OpAndi) || (opcode == OpOri);
        unique case (opcode)
          OpAndi:  alu_ctrl = AluAnd;
          OpOri:   alu_ctrl = AluOr;
          OpSlti:  alu_ctrl = AluSlt;
          default: alu_ctrl = AluAdd;
        endcase
      end
      StIWb:   reg_write = 1'b1;
      StTrap:  halted = 1'b1;
      default: halted = 1'b1;
    endcase
    if (rst) begin
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      halted        = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// Directed bench for mc_ctrl_fsm: one task per scenario, inline checks.
module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rst2 = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h20;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic        pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, ext_zero, halted;
  logic [1:0]  alu_src_b, pc_source;
  logic [3:0]  alu_ctrl, state;
  logic [31:0] cycle_count, instr_count;

  logic        s_pc_write, s_pc_write_cond, s_iord, s_mem_read, s_mem_write, s_ir_write;
  logic        s_mem_to_reg, s_reg_dst, s_reg_write, s_alu_src_a, s_ext_zero, s_halted;
  logic [1:0]  s_alu_src_b, s_pc_source;
  logic [3:0]  s_alu_ctrl, s_state;
  logic [3:0]  s_cycle_count, s_instr_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b1), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .iord(iord), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .ext_zero(ext_zero),
    .alu_ctrl(alu_ctrl), .pc_source(pc_source), .state(state), .halted(halted),
    .cycle_count(cycle_count), .instr_count(instr_count)
  );

  mc_ctrl_fsm #(.MEM_HANDSHAKE(1'b0), .CNT_W(4)) dut_small (
    .clk(clk), .rst(rst2), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .pc_write(s_pc_write), .pc_write_cond(s_pc_write_cond),
    .iord(s_iord), .mem_read(s_mem_read), .mem_write(s_mem_write),
    .ir_write(s_ir_write), .mem_to_reg(s_mem_to_reg), .reg_dst(s_reg_dst),
    .reg_write(s_reg_write), .alu_src_a(s_alu_src_a), .alu_src_b(s_alu_src_b),
    .ext_zero(s_ext_zero), .alu_ctrl(s_alu_ctrl), .pc_source(s_pc_source),
    .state(s_state), .halted(s_halted), .cycle_count(s_cycle_count),
    .instr_count(s_instr_count)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    n_vec++;
    if ({pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, halted} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b want 0000000",
               {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write, halted});
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (state !== 4'd0 || cycle_count !== 32'd0 || instr_count !== 32'd0) begin
      n_err++;
      $display("FAIL reset_state: state=%0d cyc=%0d ins=%0d want 0/0/0",
               state, cycle_count, instr_count);
    end
    n_vec++;
    if (mem_read !== 1'b1 || ir_write !== 1'b1 || pc_write !== 1'b1 || alu_src_b !== 2'b01 ||
        alu_ctrl !== 4'b0010 || iord !== 1'b0) begin
      n_err++;
      $display("FAIL fetch_outputs: mr=%b irw=%b pcw=%b srcb=%b alu=%b iord=%b want 1 1 1 01 0010 0",
               mem_read, ir_write, pc_write, alu_src_b, alu_ctrl, iord);
    end
  endtask

  task automatic test_lw();
    logic [3:0] path [6];
    path = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    do_reset();
    opcode = 6'h23;
    mem_ready = 1'b1;
    #1;
    for (int i = 0; i < 6; i++) begin
      n_vec++;
      if (state !== path[i]) begin
        n_err++;
        $display("FAIL lw_path[%0d]: state=%0d want %0d", i, state, path[i]);
      end
      if (i == 4) begin
        n_vec++;
        if (reg_write !== 1'b1 || mem_to_reg !== 1'b1 || reg_dst !== 1'b0) begin
          n_err++;
          $display("FAIL lw_memwb: rw=%b m2r=%b rd=%b want 1 1 0", reg_write, mem_to_reg, reg_dst);
        end
      end
      if (i < 5) tick();
    end
    n_vec++;
    if (instr_count !== 32'd1 || cycle_count !== 32'd5) begin
      n_err++;
      $display("FAIL lw_counts: ins=%0d cyc=%0d want 1 5", instr_count, cycle_count);
    end
  endtask

  task automatic test_sw_wait();
    int writes = 0;
    do_reset();
    opcode = 6'h2B;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    n_vec++;
    if (state !== 4'd5) begin
      n_err++;
      $display("FAIL sw_reach_memwr: state=%0d want 5", state);
    end
    for (int i = 0; i < 4; i++) begin
      mem_ready = (i == 3);
      #1;
      if (mem_write === 1'b1 && state === 4'd5) writes++;
      tick();
    end
    n_vec++;
    if (writes !== 4) begin
      n_err++;
      $display("FAIL sw_write_cycles: got %0d want 4", writes);
    end
    n_vec++;
    if (state !== 4'd0 || instr_count !== 32'd1 || cycle_count !== 32'd7) begin
      n_err++;
      $display("FAIL sw_retire: state=%0d ins=%0d cyc=%0d want 0 1 7",
               state, instr_count, cycle_count);
    end
  endtask

  task automatic test_branch();
    do_reset();
    opcode = 6'h04;
    zero = 1'b1;
    tick(); tick();
    n_vec++;
    if (state !== 4'd8 || pc_write_cond !== 1'b1 || pc_source !== 2'b01 || pc_write !== 1'b0 ||
        alu_ctrl !== 4'b0110) begin
      n_err++;
      $display("FAIL beq_taken: st=%0d pwc=%b src=%b pw=%b alu=%b want 8 1 01 0 0110",
               state, pc_write_cond, pc_source, pc_write, alu_ctrl);
    end
    tick();
    n_vec++;
    if (state !== 4'd0 || cycle_count !== 32'd3 || instr_count !== 32'd1) begin
      n_err++;
      $display("FAIL beq_retire: st=%0d cyc=%0d ins=%0d want 0 3 1",
               state, cycle_count, instr_count);
    end
    opcode = 6'h05;
    tick(); tick();
    n_vec++;
    if (state !== 4'd8 || pc_write_cond !== 1'b0) begin
      n_err++;
      $display("FAIL bne_zero1: st=%0d pwc=%b want 8 0", state, pc_write_cond);
    end
    zero = 1'b0;
    #1;
    n_vec++;
    if (pc_write_cond !== 1'b1) begin
      n_err++;
      $display("FAIL bne_zero0: pwc=%b want 1", pc_write_cond);
    end
    tick();
    n_vec++;
    if (state !== 4'd0 || cycle_count !== 32'd6 || instr_count !== 32'd2) begin
      n_err++;
      $display("FAIL bne_retire: st=%0d cyc=%0d ins=%0d want 0 6 2",
               state, cycle_count, instr_count);
    end
  endtask

  task automatic test_rtype_trap();
    do_reset();
    opcode = 6'h00;
    funct = 6'h22;
    tick(); tick();
    n_vec++;
    if (state !== 4'd6 || alu_ctrl !== 4'b0110 || alu_src_a !== 1'b1 || alu_src_b !== 2'b00) begin
      n_err++;
      $display("FAIL rtype_sub: st=%0d alu=%b a=%b b=%b want 6 0110 1 00",
               state, alu_ctrl, alu_src_a, alu_src_b);
    end
    tick();
    n_vec++;
    if (state !== 4'd7 || reg_write !== 1'b1 || reg_dst !== 1'b1 || mem_to_reg !== 1'b0) begin
      n_err++;
      $display("FAIL rtype_wb: st=%0d rw=%b rd=%b m2r=%b want 7 1 1 0",
               state, reg_write, reg_dst, mem_to_reg);
    end
    tick();
    funct = 6'h3F;
    tick(); tick(); tick();
    n_vec++;
    if (state !== 4'd12 || halted !== 1'b1 || cycle_count !== 32'd7 || instr_count !== 32'd1) begin
      n_err++;
      $display("FAIL rtype_trap: st=%0d h=%b cyc=%0d ins=%0d want 12 1 7 1",
               state, halted, cycle_count, instr_count);
    end
    repeat (10) tick();
    n_vec++;
    if (state !== 4'd12 || cycle_count !== 32'd7 || instr_count !== 32'd1 ||
        {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write} !== 6'b0) begin
      n_err++;
      $display("FAIL trap_frozen: st=%0d cyc=%0d ins=%0d en=%b want 12 7 1 000000", state,
               cycle_count, instr_count,
               {pc_write, pc_write_cond, mem_read, mem_write, ir_write, reg_write});
    end
    rst = 1'b1;
    #1;
    n_vec++;
    if (halted !== 1'b0) begin
      n_err++;
      $display("FAIL trap_rst_halted: h=%b want 0", halted);
    end
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (state !== 4'd0 || cycle_count !== 32'd0) begin
      n_err++;
      $display("FAIL trap_exit: st=%0d cyc=%0d want 0 0", state, cycle_count);
    end
  endtask

  task automatic test_itype();
    do_reset();
    opcode = 6'h0D;
    tick(); tick();
    n_vec++;
    if (state !== 4'd10 || ext_zero !== 1'b1 || alu_ctrl !== 4'b0001 || alu_src_b !== 2'b10) begin
      n_err++;
      $display("FAIL ori_exec: st=%0d ez=%b alu=%b b=%b want 10 1 0001 10",
               state, ext_zero, alu_ctrl, alu_src_b);
    end
    tick();
    n_vec++;
    if (state !== 4'd11 || reg_write !== 1'b1 || reg_dst !== 1'b0) begin
      n_err++;
      $display("FAIL ori_wb: st=%0d rw=%b rd=%b want 11 1 0", state, reg_write, reg_dst);
    end
    tick();
    n_vec++;
    if (state !== 4'd0 || instr_count !== 32'd1) begin
      n_err++;
      $display("FAIL ori_retire: st=%0d ins=%0d want 0 1", state, instr_count);
    end
    opcode = 6'h3F;
    tick(); tick();
    n_vec++;
    if (state !== 4'd12 || halted !== 1'b1) begin
      n_err++;
      $display("FAIL bad_opcode: st=%0d h=%b want 12 1", state, halted);
    end
  endtask

  task automatic test_saturate();
    rst = 1'b1;
    opcode = 6'h00;
    funct = 6'h20;
    mem_ready = 1'b0;
    rst2 = 1'b1;
    tick();
    rst2 = 1'b0;
    #1;
    n_vec++;
    if (s_ir_write !== 1'b1 || s_state !== 4'd0) begin
      n_err++;
      $display("FAIL nohs_fetch: irw=%b st=%0d want 1 0", s_ir_write, s_state);
    end
    repeat (20) tick();
    n_vec++;
    if (s_cycle_count !== 4'd15 || s_instr_count !== 4'd5 || s_state !== 4'd0) begin
      n_err++;
      $display("FAIL saturate: cyc=%0d ins=%0d st=%0d want 15 5 0",
               s_cycle_count, s_instr_count, s_state);
    end
    rst2 = 1'b1;
    mem_ready = 1'b1;
  endtask

  task automatic test_rst_memrd();
    do_reset();
    opcode = 6'h23;
    mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick();
    n_vec++;
    if (state !== 4'd3 || mem_read !== 1'b1 || iord !== 1'b1) begin
      n_err++;
      $display("FAIL memrd_wait: st=%0d mr=%b iord=%b want 3 1 1", state, mem_read, iord);
    end
    rst = 1'b1;
    mem_ready = 1'b1;
    #1;
    n_vec++;
    if (mem_read !== 1'b0 || reg_write !== 1'b0 || mem_write !== 1'b0) begin
      n_err++;
      $display("FAIL memrd_rst_strobes: mr=%b rw=%b mw=%b want 0 0 0",
               mem_read, reg_write, mem_write);
    end
    tick();
    rst = 1'b0;
    #1;
    n_vec++;
    if (state !== 4'd0 || cycle_count !== 32'd0 || instr_count !== 32'd0 || reg_write !== 1'b0) begin
      n_err++;
      $display("FAIL memrd_rst: st=%0d cyc=%0d ins=%0d rw=%b want 0 0 0 0",
               state, cycle_count, instr_count, reg_write);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, elapsed %0t want below 200000", $time);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_branch();
    test_rtype_trap();
    test_itype();
    test_saturate();
    test_rst_memrd();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
- Parametrised multi-cycle MIPS control unit for the next-generation multi-cycle CPU.
- Sequences FETCH/DECODE/EXECUTE/MEM/WRITEBACK per instruction and drives datapath selects and enables.
- Extends the base instruction set (lw, sw, R-type, beq, j) with bne, addi, andi, ori and slti.
- Adds a memory ready handshake, a trap state for illegal encodings, and saturating cycle/instruction counters.

Parameters:
- MEM_HANDSHAKE, 1, when 0 mem_ready is ignored and treated as constant 1.
- CNT_W, 32, width of cycle_count and instr_count.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- zero  in  1  ALU zero flag from the current cycle.
- mem_ready  in  1  memory access completes this cycle.
- pc_write  out  1  unconditional PC load.
- pc_write_cond  out  1  conditional PC load, already resolved against zero.
- iord  out  1  0 = address from PC, 1 = address from ALUOut.
- mem_read  out  1  memory read strobe.
- mem_write  out  1  memory write strobe.
- ir_write  out  1  IR load.
- mem_to_reg  out  1  write-back data from MDR.
- reg_dst  out  1  destination is rd (1) or rt (0).
- reg_write  out  1  register file write.
- alu_src_a  out  1  0 = PC, 1 = A.
- alu_src_b  out  2  00 = B, 01 = 4, 10 = imm extended, 11 = sign-extended imm<<2.
- ext_zero  out  1  zero-extend imm (andi/ori).
- alu_ctrl  out  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
- pc_source  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding.
- halted  out  1  in TRAP.
- cycle_count  out  CNT_W  non-halted cycles since reset.
- instr_count  out  CNT_W  retired instructions.

Behaviour:
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BRANCH=8, JUMP=9, IEXEC=10, IWB=11, TRAP=12.
- Reset: state becomes FETCH and both counters become 0. While rst is high, all enables and strobes are forced to 0 and halted=0.
- Outputs are Moore decodes of state. Exception: write enables in memory states are gated by mem_ready.

FETCH:
- iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, alu_ctrl=add, pc_source=00.
- ir_write and pc_write = mem_ready.
- Stays in FETCH while mem_ready=0; moves to DECODE when mem_ready=1.

DECODE:
- alu_src_a=0, alu_src_b=11, alu_ctrl=add (branch target computed into ALUOut).
- Next state by opcode:
  - 0x23 lw, 0x2B sw → MEMADR
  - 0x00 R-type → REXEC
  - 0x04 beq, 0x05 bne → BRANCH
  - 0x02 j → JUMP
  - 0x08 addi, 0x0C andi, 0x0D ori, 0x0A slti → IEXEC
  - any other opcode → TRAP

MEMADR:
- alu_src_a=1, alu_src_b=10, ext_zero=0, add.
- Next is MEMRD for lw, MEMWR for sw.

MEMRD:
- iord=1, mem_read=1.
- Waits while mem_ready=0; goes to MEMWB on mem_ready=1.

MEMWB:
- reg_write=1, mem_to_reg=1, reg_dst=0.
- Next is FETCH; retires.

MEMWR:
- iord=1, mem_write=1 for every cycle in this state.
- Retires and moves to FETCH on mem_ready=1.

REXEC:
- alu_src_a=1, alu_src_b=00.
- funct mapping: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt.
- A recognised funct goes to RWB. Any other funct goes to TRAP.

RWB:
- reg_write=1, reg_dst=1, mem_to_reg=0.
- Next is FETCH; retires.

BRANCH:
- alu_src_a=1, alu_src_b=00, sub, pc_source=01.
- pc_write_cond = zero for beq, ~zero for bne.
- Next is FETCH; retires.

JUMP:
- pc_write=1, pc_source=10.
- Next is FETCH; retires.

IEXEC:
- alu_src_a=1, alu_src_b=10.
- ext_zero=1 for andi/ori.
- alu_ctrl: add for addi, and for andi, or for ori, slt for slti.
- Next is IWB.

IWB:
- reg_write=1, reg_dst=0, mem_to_reg=0.
- Next is FETCH; retires.

TRAP:
- halted=1 and all enables are 0.
- TRAP is absorbing until rst; counters freeze.

Counters:
- cycle_count increments every non-reset cycle while not in TRAP.
- instr_count increments on the cycle a retiring state transitions to FETCH.
- Both counters saturate at all-ones and never wrap.

Other rules:
- Any output not listed for a state is 0.
- pc_write and pc_write_cond are never both 1.
- rst asserted in any state, including a memory wait or TRAP, returns to FETCH on the next edge with no write strobe in that cycle.

Test Plan:
- Reset, then lw (0x23) with mem_ready=1 throughout → state path 0,1,2,3,4,0; instr_count=1, cycle_count=5 when back in FETCH.
- sw with mem_ready low for 3 cycles in MEMWR → mem_write=1 for 4 cycles, single retirement, instr_count=1.
- beq with zero=1 → pc_write_cond=1, pc_source=01; bne with zero=1 → pc_write_cond=0; both take 3 cycles.
- R-type funct=0x22 → alu_ctrl=0110 in REXEC; funct=0x3F → TRAP, halted=1, counters frozen for 10 cycles.
- ori (0x0D) → ext_zero=1, alu_ctrl=0001, reg_write=1 in IWB; opcode 0x3F → TRAP from DECODE.
- CNT_W=4, run 20 cycles of add instructions → cycle_count saturates at 15; rst mid-MEMRD → state=0, counters=0, no reg_write.
